// File: rtl/issue_gate_if.sv
// Decode-to-issue handshake plus the scoreboard write-claim bus driven on issue.
interface issue_gate_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_ra;
  logic [2:0] in_rb;
  logic       in_use_ra;
  logic       in_use_rb;
  logic       in_regwrite;
  logic [2:0] in_rd;
  logic       in_load;
  logic       issue;
  logic [2:0] out_ra;
  logic [2:0] out_rb;
  logic [2:0] out_rd;
  logic       regwrite_cur;
  logic       from_main_mem;
  logic [2:0] regwrite_adr_id;

  modport master (
    output in_valid, in_ra, in_rb, in_use_ra, in_use_rb, in_regwrite, in_rd, in_load,
    input  in_ready, issue, out_ra, out_rb, out_rd, regwrite_cur, from_main_mem, regwrite_adr_id
  );

  modport slave (
    input  in_valid, in_ra, in_rb, in_use_ra, in_use_rb, in_regwrite, in_rd, in_load,
    output in_ready, issue, out_ra, out_rb, out_rd, regwrite_cur, from_main_mem, regwrite_adr_id
  );
endinterface

// File: rtl/issue_gate.sv
// One-entry issue slot: holds a decoded instruction until its source and
// destination scoreboard counters drop to a forwardable value, then issues it.
module issue_gate #(
  parameter int FWD_OK = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  issue_gate_if.slave      gate,
  input  logic [2:0]       register_invalid [7:0],
  input  logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_total
);
  localparam logic [2:0] FWD_LIM = 3'(FWD_OK);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] ra_q, rb_q, rd_q;
  logic       use_ra_q, use_rb_q, rw_q, ld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic held, hazard, issue_c, stall_c, ready_c, accept;

  // Counters above FWD_LIM mean the value is not yet forwardable.
  always_comb begin
    held   = (state_q == HELD);
    hazard = held & ((use_ra_q & (register_invalid[ra_q] > FWD_LIM)) |
                     (use_rb_q & (register_invalid[rb_q] > FWD_LIM)) |
                     (rw_q     & (register_invalid[rd_q] > FWD_LIM)));
  end

  // Output process; everything is forced low while reset is asserted.
  always_comb begin
    issue_c = reset & held & ~hazard & ~flush;
    stall_c = reset & held &  hazard & ~flush;
    ready_c = reset & (~held | issue_c | flush);
    accept  = gate.in_valid & ready_c;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                state_d = HELD;
    else if (issue_c || flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      use_ra_q <= 1'b0;
      use_rb_q <= 1'b0;
      rw_q     <= 1'b0;
      ld_q     <= 1'b0;
    end else if (accept) begin
      ra_q     <= gate.in_ra;
      rb_q     <= gate.in_rb;
      rd_q     <= gate.in_rd;
      use_ra_q <= gate.in_use_ra;
      use_rb_q <= gate.in_use_rb;
      rw_q     <= gate.in_regwrite;
      ld_q     <= gate.in_load;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign gate.in_ready        = ready_c;
  assign gate.issue           = issue_c;
  assign gate.out_ra          = reset ? ra_q : 3'd0;
  assign gate.out_rb          = reset ? rb_q : 3'd0;
  assign gate.out_rd          = reset ? rd_q : 3'd0;
  assign gate.regwrite_cur    = issue_c & rw_q;
  assign gate.from_main_mem   = reset & ld_q;
  assign gate.regwrite_adr_id = reset ? rd_q : 3'd0;
  assign stall                = stall_c;
  assign stall_total          = cnt_q;
endmodule

// File: doc/issue_gate.md
Name: issue_gate

Overview:
- Consumer and producer end of the register scoreboard interface.
- Holds one decoded instruction and compares its source registers against the per-register invalid counters (register_invalid).
- Stalls the instruction until its operands are usable, then issues it.
- On issue, drives the scoreboard write-claim signals (regwrite_cur, from_main_mem, regwrite_adr_id) for the issuing instruction's destination register.
- Sits between decode and execute.

Parameters:
- FWD_OK, 1: highest counter value still treated as operand-ready (the value is forwardable).
- CNT_W, 8: width of the stall statistic counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  the block accepts the instruction this cycle.
- in_ra  in  3  source register A.
- in_rb  in  3  source register B.
- in_use_ra  in  1  source A is read.
- in_use_rb  in  1  source B is read.
- in_regwrite  in  1  the instruction writes a register.
- in_rd  in  3  destination register.
- in_load  in  1  the result comes from main memory.
- register_invalid  in  8x3  unpacked [7:0] array of scoreboard counters; 0 = valid.
- flush  in  1  discard the held instruction (branch taken).
- issue  out  1  the held instruction issues this cycle.
- out_ra, out_rb, out_rd  out  3 each  fields of the issuing instruction.
- regwrite_cur  out  1  scoreboard claim enable.
- from_main_mem  out  1  scoreboard claim type.
- regwrite_adr_id  out  3  scoreboard claim register.
- stall  out  1  the held instruction is blocked this cycle.
- stall_total  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State machine has two states, EMPTY and HELD. Reset (reset=0) forces EMPTY immediately.
- All held fields reset to 0. stall_total resets to 0.
- Every output that is combinationally derived from state is 0 while in reset.
- hazard = HELD & ((use_ra & register_invalid[ra] > FWD_OK) | (use_rb & register_invalid[rb] > FWD_OK)).
- A WAW hazard also counts: HELD & regwrite & register_invalid[rd] > FWD_OK.
- issue = HELD & ~hazard & ~flush, combinational from held state and the current register_invalid.
- stall = HELD & hazard & ~flush.
- in_ready = EMPTY | issue | flush. The held slot frees in the same cycle, so back-to-back issue is possible.
- Latency: an instruction accepted at edge N can issue no earlier than the cycle following edge N (one cycle minimum).
- Accept happens when in_valid & in_ready. The fields are captured and the state becomes (or stays) HELD.
- Without an accept, an issue or flush moves the state to EMPTY.
- Simultaneous flush and in_valid: the held instruction is dropped and the new one is captured. It is not itself flushed; decode must deassert in_valid on the flush cycle if it is also stale.
- Scoreboard claim outputs:
  - regwrite_cur = issue & held regwrite.
  - from_main_mem = held load.
  - regwrite_adr_id = held rd.
  - from_main_mem and regwrite_adr_id are ignored by the scoreboard when regwrite_cur = 0.
- Register 0 is not special; hazards are checked on it like any other register.
- stall_total increments on every cycle with stall=1 and saturates at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall: the held instruction is lost, nothing issues, and stall_total clears.
- The counter compare is unsigned 3-bit. Values 0..FWD_OK are ready.

Test Plan:
- Back-to-back independent instructions, with in_valid held and all counters 0 → issue=1 every cycle from cycle 1; stall_total=0.
- Held instruction with ra=3, register_invalid[3] counting 3,2,1,0 → stall for 2 cycles, issue on the cycle the counter reads 1; stall_total=2.
- Load claim: issuing instruction with regwrite=1, rd=5, load=1 → regwrite_cur=1, from_main_mem=1, regwrite_adr_id=5 on the issue cycle only.
- flush while stalled on rb=7 with register_invalid[7]=2 → no issue; next cycle EMPTY, regwrite_cur never asserts.
- WAW: rd=2, register_invalid[2]=2, sources unused → stall until the counter reaches 1.
- Saturation with CNT_W=2: 5 stall cycles → stall_total=3. Assert reset mid-stall → stall_total=0, issue=0, in_ready=1 after release.
